// File: rtl/exe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | exe_pkg : shared Y86-64 execute-stage constants, CC type, cond eval |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package exe_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_MUL  = 4'h4;

  localparam logic [3:0] C_YES    = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  localparam int MUL_ITERS = 64;
  localparam int MUL_CNT_W = $clog2(MUL_ITERS);

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  function automatic logic cond_eval(input logic [3:0] fn, input cc_t cc);
    logic w_res;
    w_res = 1'b0;
    case (fn)
      C_YES:   w_res = 1'b1;
      C_LE:    w_res = (cc.sf ^ cc.of) | cc.zf;
      C_L:     w_res = cc.sf ^ cc.of;
      C_E:     w_res = cc.zf;
      C_NE:    w_res = ~cc.zf;
      C_GE:    w_res = ~(cc.sf ^ cc.of);
      C_G:     w_res = ~(cc.sf ^ cc.of) & ~cc.zf;
      default: w_res = 1'b0;
    endcase
    return w_res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_mul_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_iter : 64-iteration shift-add multiplier, low 64 product bits   |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module mul_iter
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        done,
  output logic [63:0] product
);

  logic                 r_busy;
  logic [MUL_CNT_W-1:0] r_cnt;
  logic [63:0]          r_acc;
  logic [63:0]          r_mcand;
  logic [63:0]          r_mplier;
  logic [63:0]          w_acc_nxt;

  assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
    end else if (r_busy) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

  // The final iteration is folded into the output so the caller can register it on edge 64.
  assign done    = r_busy && (r_cnt == MUL_CNT_W'(MUL_ITERS - 1));
  assign product = w_acc_nxt;

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | execute_stage : Y86-64 ALU/CC/condition stage; optional mulq via    |
// | EXE_MUL_EN.  Revision: 1.0                                          |
// +--------------------------------------------------------------------+
module execute_stage
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valC,
  output logic        out_valid,
  output logic [63:0] valE,
  output logic        cnd,
  output logic        zf,
  output logic        sf,
  output logic        of,
  output logic        err
);

  logic        r_out_valid;
  logic [63:0] r_valE;
  logic        r_cnd;
  logic        r_err;
  cc_t         r_cc;

  logic        w_in_ready;
  logic        w_accept;
  logic [63:0] w_sum;
  logic [63:0] w_diff;
  logic [63:0] w_valE;
  logic        w_cnd;
  logic        w_err;
  logic        w_upd_cc;
  logic        w_of;
  logic        w_is_mul;
  logic        w_mul_fin;
  logic [63:0] w_mul_prod;

  assign w_accept = in_valid & w_in_ready;
  assign w_sum    = valB + valA;
  assign w_diff   = valB - valA;

  always_comb begin
    w_valE   = '0;
    w_cnd    = 1'b0;
    w_err    = 1'b0;
    w_upd_cc = 1'b0;
    w_of     = 1'b0;
    w_is_mul = 1'b0;
    case (icode)
      I_HALT, I_NOP, I_JXX: begin
        if (icode == I_JXX) begin
          if (ifun > C_G) w_err = 1'b1;
          else            w_cnd = cond_eval(ifun, r_cc);
        end
      end
      I_CMOVXX: begin
        if (ifun > C_G) begin
          w_err = 1'b1;
        end else begin
          w_valE = valA;
          w_cnd  = cond_eval(ifun, r_cc);
        end
      end
      I_IRMOVQ:          w_valE = valC;
      I_RMMOVQ, I_MRMOVQ: w_valE = valB + valC;
      I_OPQ: begin
        case (ifun)
          ALU_ADD: begin
            w_valE   = w_sum;
            w_upd_cc = 1'b1;
            w_of     = (valA[63] == valB[63]) && (w_sum[63] != valB[63]);
          end
          ALU_SUB: begin
            w_valE   = w_diff;
            w_upd_cc = 1'b1;
            w_of     = (valA[63] != valB[63]) && (w_diff[63] != valB[63]);
          end
          ALU_AND: begin
            w_valE   = valB & valA;
            w_upd_cc = 1'b1;
          end
          ALU_XOR: begin
            w_valE   = valB ^ valA;
            w_upd_cc = 1'b1;
          end
`ifdef EXE_MUL_EN
          ALU_MUL: w_is_mul = 1'b1;
`endif
          default: w_err = 1'b1;
        endcase
      end
      I_CALL, I_PUSHQ: w_valE = valB - 64'd8;
      I_RET, I_POPQ:   w_valE = valB + 64'd8;
      default:         w_err = 1'b1;
    endcase
  end

`ifdef EXE_MUL_EN
  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_mul_start;
  logic   w_mul_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (w_mul_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_in_ready  = (r_state == S_IDLE);
  assign w_mul_start = w_accept & w_is_mul;
  assign w_mul_fin   = (r_state == S_MUL) && w_mul_done;

  mul_iter u_mul_iter (
    .clk     (clk),
    .rst     (rst),
    .start   (w_mul_start),
    .a       (valA),
    .b       (valB),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );
`else
  assign w_in_ready = 1'b1;
  assign w_mul_fin  = 1'b0;
  assign w_mul_prod = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_valE      <= '0;
      r_cnd       <= 1'b0;
      r_err       <= 1'b0;
      r_cc        <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && !w_is_mul) begin
        r_out_valid <= 1'b1;
        r_valE      <= w_valE;
        r_cnd       <= w_cnd;
        r_err       <= w_err;
        if (w_upd_cc) begin
          r_cc <= '{zf: (w_valE == 64'd0), sf: w_valE[63], of: w_of};
        end
      end else if (w_mul_fin) begin
        r_out_valid <= 1'b1;
        r_valE      <= w_mul_prod;
        r_cnd       <= 1'b0;
        r_err       <= 1'b0;
        r_cc        <= '{zf: (w_mul_prod == 64'd0), sf: w_mul_prod[63], of: 1'b0};
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign valE      = r_valE;
  assign cnd       = r_cnd;
  assign err       = r_err;
  assign zf        = r_cc.zf;
  assign sf        = r_cc.sf;
  assign of        = r_cc.of;

endmodule
`default_nettype wire
